// File: rtl/counter_mod_updown_pkg.sv
// Shared definitions for the modulus up/down counter: boundary modes and the
// terminal-value computation used by every instance.
package counter_mod_updown_pkg;

   typedef enum logic [0:0] {
      MODE_WRAP = 1'b0,
      MODE_SAT  = 1'b1
   } mode_e;

   localparam int unsigned WIDTH_MAX = 32;

   // Terminal value MODULUS-1; kept 64-bit so MODULUS = 2**32 is representable.
   function automatic longint unsigned max_value(input longint unsigned modulus);
      return modulus - 64'd1;
   endfunction

   function automatic mode_e mode_from_int(input int mode);
      if (mode == 1) begin
         return MODE_SAT;
      end else begin
         return MODE_WRAP;
      end
   endfunction

endpackage

// File: rtl/counter_mod_updown_next.sv
// Combinational next-state logic: load clamp, +/-1 step with wrap or saturate
// at the modulus boundary, and the raw terminal-count term.
module counter_mod_updown_next
   import counter_mod_updown_pkg::*;
#(
   parameter int              WIDTH   = 16,
   parameter longint unsigned MODULUS = 64'd65536
) (
   input  logic [WIDTH-1:0] i_q,
   input  logic             i_up,
   input  logic             i_ld,
   input  logic [WIDTH-1:0] i_d,
   input  mode_e            i_mode,
   output logic [WIDTH-1:0] o_next,
   output logic             o_bound,
   output logic             o_tc
);

   // MODULUS-1 is formed at WIDTH+1 bits, then narrowed; it always fits WIDTH.
   localparam logic [WIDTH:0]   MAXVAL_X = (WIDTH+1)'(max_value(MODULUS));
   localparam logic [WIDTH-1:0] MAXVAL   = MAXVAL_X[WIDTH-1:0];
   localparam logic [WIDTH-1:0] ZERO     = WIDTH'(0);
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

   logic w_at_max;
   logic w_at_zero;

   assign w_at_max  = (i_q == MAXVAL);
   assign w_at_zero = (i_q == ZERO);

   // Boundary in the current direction of travel.
   always_comb begin
      o_bound = 1'b0;
      if (i_up) begin
         o_bound = w_at_max;
      end else begin
         o_bound = w_at_zero;
      end
   end

   // Next count value: load wins, otherwise one step with boundary handling.
   always_comb begin
      o_next = i_q;
      if (i_ld) begin
         if (i_d > MAXVAL) begin
            o_next = MAXVAL;
         end else begin
            o_next = i_d;
         end
      end else if (o_bound) begin
         if (i_mode == MODE_SAT) begin
            o_next = i_q;
         end else if (i_up) begin
            o_next = ZERO;
         end else begin
            o_next = MAXVAL;
         end
      end else if (i_up) begin
         o_next = i_q + ONE;
      end else begin
         o_next = i_q - ONE;
      end
   end

   // Terminal count before the enable and clear gating applied at the top.
   always_comb begin
      o_tc = o_bound & ~i_ld;
   end

endmodule

// File: rtl/counter_mod_updown.sv
// Parametrised synchronous up/down modulus counter with load, wrap/saturate,
// a same-cycle terminal count for cascading and a registered overflow pulse.
module counter_mod_updown
   import counter_mod_updown_pkg::*;
#(
   parameter int              WIDTH   = 16,
   parameter longint unsigned MODULUS = 64'd65536,
   parameter int              MODE    = 0
) (
   input  logic             Clk,
   input  logic             Clr,
   input  logic             En,
   input  logic             Up,
   input  logic             Ld,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             Tc,
   output logic             Ovf
);

   localparam mode_e MODE_E = mode_from_int(MODE);

   logic [WIDTH-1:0] r_q;
   logic             r_ovf;
   logic [WIDTH-1:0] w_next;
   logic             w_bound;
   logic             w_tc_raw;

   counter_mod_updown_next #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_next (
      .i_q     (r_q),
      .i_up    (Up),
      .i_ld    (Ld),
      .i_d     (D),
      .i_mode  (MODE_E),
      .o_next  (w_next),
      .o_bound (w_bound),
      .o_tc    (w_tc_raw)
   );

   // Count and overflow registers; priority Clr > Ld > En, one action per edge.
   always_ff @(posedge Clk) begin
      if (Clr) begin
         r_q   <= WIDTH'(0);
         r_ovf <= 1'b0;
      end else if (Ld) begin
         r_q   <= w_next;
         r_ovf <= 1'b0;
      end else if (En) begin
         r_q   <= w_next;
         r_ovf <= w_bound;
      end else begin
         r_q   <= r_q;
         r_ovf <= 1'b0;
      end
   end

   assign Q   = r_q;
   assign Ovf = r_ovf;
   // Zero-latency so a downstream stage steps on the same edge as this one wraps.
   assign Tc  = En & ~Clr & w_tc_raw;

endmodule

// File: tb/tb_counter_mod_updown.sv
// Randomised and directed check of counter_mod_updown instances against an
// integer-arithmetic reference model, including a two-digit decimal cascade.
module tb_counter_mod_updown;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        clr, en, up, ld;
   logic [15:0] d;

   logic [3:0]  qa, qb, q0, q1;
   logic [15:0] qc;
   logic [2:0]  qe;
   logic        tca, tcb, tcc, tce, tc0, tc1;
   logic        ovfa, ovfb, ovfc, ovfe, ovf0, ovf1;

   counter_mod_updown #(.WIDTH(4), .MODULUS(10), .MODE(0)) u_a (
      .Clk(clk), .Clr(clr), .En(en), .Up(up), .Ld(ld), .D(d[3:0]),
      .Q(qa), .Tc(tca), .Ovf(ovfa));
   counter_mod_updown #(.WIDTH(4), .MODULUS(10), .MODE(1)) u_b (
      .Clk(clk), .Clr(clr), .En(en), .Up(up), .Ld(ld), .D(d[3:0]),
      .Q(qb), .Tc(tcb), .Ovf(ovfb));
   counter_mod_updown #(.WIDTH(16), .MODULUS(65536), .MODE(0)) u_c (
      .Clk(clk), .Clr(clr), .En(en), .Up(up), .Ld(ld), .D(d),
      .Q(qc), .Tc(tcc), .Ovf(ovfc));
   counter_mod_updown #(.WIDTH(3), .MODULUS(5), .MODE(1)) u_e (
      .Clk(clk), .Clr(clr), .En(en), .Up(up), .Ld(ld), .D(d[2:0]),
      .Q(qe), .Tc(tce), .Ovf(ovfe));
   counter_mod_updown #(.WIDTH(4), .MODULUS(10), .MODE(0)) u_s0 (
      .Clk(clk), .Clr(clr), .En(en), .Up(up), .Ld(ld), .D(d[3:0]),
      .Q(q0), .Tc(tc0), .Ovf(ovf0));
   counter_mod_updown #(.WIDTH(4), .MODULUS(10), .MODE(0)) u_s1 (
      .Clk(clk), .Clr(clr), .En(tc0), .Up(up), .Ld(ld), .D(d[7:4]),
      .Q(q1), .Tc(tc1), .Ovf(ovf1));

   int n_checks = 0;
   int n_pass   = 0;
   bit valid    = 1'b0;

   longint mods  [4] = '{64'd10, 64'd10, 64'd65536, 64'd5};
   bit     sats  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
   int     widths[4] = '{4, 4, 16, 3};
   longint mq    [4];
   bit     movf  [4];
   longint vcas;
   bit     vovf;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] get_q(input int i);
      case (i)
         0:       return {60'd0, qa};
         1:       return {60'd0, qb};
         2:       return {48'd0, qc};
         default: return {61'd0, qe};
      endcase
   endfunction

   function automatic logic get_tc(input int i);
      case (i)
         0:       return tca;
         1:       return tcb;
         2:       return tcc;
         default: return tce;
      endcase
   endfunction

   function automatic logic get_ovf(input int i);
      case (i)
         0:       return ovfa;
         1:       return ovfb;
         2:       return ovfc;
         default: return ovfe;
      endcase
   endfunction

   function automatic longint clamp(input longint v, input longint m);
      return (v > m - 1) ? m - 1 : v;
   endfunction

   task automatic set_in(input bit c, input bit l, input bit e, input bit u, input logic [15:0] dd);
      clr = c; ld = l; en = e; up = u; d = dd;
   endtask

   // One clock: check Tc before the edge, advance the model, check Q/Ovf after.
   task automatic cycle();
      bit     step;
      bit     bnd;
      longint dv;
      step = en && !ld && !clr;
      #1;
      for (int i = 0; i < 4; i++) begin
         dv  = longint'(d) % (64'd1 << widths[i]);
         bnd = up ? (mq[i] == mods[i] - 1) : (mq[i] == 0);
         if (valid) check_eq($sformatf("tc%0d", i), {63'd0, get_tc(i)}, {63'd0, step && bnd});
         movf[i] = 1'b0;
         if (clr) begin
            mq[i] = 0;
         end else if (ld) begin
            mq[i] = clamp(dv, mods[i]);
         end else if (en) begin
            movf[i] = bnd;
            if (!(bnd && sats[i])) mq[i] = (mq[i] + (up ? 1 : mods[i] - 1)) % mods[i];
         end
      end
      bnd = up ? (vcas == 99) : (vcas == 0);
      if (valid) check_eq("tc_cascade", {63'd0, tc1}, {63'd0, step && bnd});
      vovf = 1'b0;
      if (clr) begin
         vcas = 0;
      end else if (ld) begin
         vcas = clamp(longint'(d[7:4]), 10) * 10 + clamp(longint'(d[3:0]), 10);
      end else if (en) begin
         vovf = bnd;
         vcas = (vcas + (up ? 1 : 99)) % 100;
      end
      @(posedge clk);
      #1;
      if (clr) valid = 1'b1;
      if (valid) begin
         for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("q%0d", i), get_q(i), mq[i]);
            check_eq($sformatf("ovf%0d", i), {63'd0, get_ovf(i)}, {63'd0, movf[i]});
         end
         check_eq("q_cascade", 64'(q1) * 10 + 64'(q0), vcas);
         check_eq("ovf_cascade", {63'd0, ovf1}, {63'd0, vovf});
      end
   endtask

   initial begin
      set_in(1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
      @(negedge clk);

      // Reset wins over load and enable.
      set_in(1'b1, 1'b1, 1'b1, 1'b1, 16'd7);
      cycle();
      check_eq("rst_q", {60'd0, qa}, 64'd0);
      check_eq("rst_ovf", {63'd0, ovfa}, 64'd0);

      // Clear aborts a running count.
      set_in(1'b0, 1'b0, 1'b1, 1'b1, 16'd0);
      repeat (5) cycle();
      set_in(1'b1, 1'b0, 1'b1, 1'b1, 16'd0);
      cycle();
      check_eq("clr_mid_q", {60'd0, qa}, 64'd0);

      // Up-count through the wrap.
      set_in(1'b0, 1'b0, 1'b1, 1'b1, 16'd0);
      repeat (9) cycle();
      check_eq("wrap_tc_at9", {63'd0, tca}, 64'd1);
      cycle();
      check_eq("wrap_q", {60'd0, qa}, 64'd0);
      check_eq("wrap_ovf", {63'd0, ovfa}, 64'd1);

      // Down-count into saturation.
      set_in(1'b0, 1'b1, 1'b0, 1'b0, 16'd2);
      cycle();
      set_in(1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
      cycle();
      cycle();
      check_eq("sat_q_e2", {60'd0, qb}, 64'd0);
      check_eq("sat_ovf_e2", {63'd0, ovfb}, 64'd0);
      cycle();
      check_eq("sat_ovf_e3", {63'd0, ovfb}, 64'd1);
      cycle();
      check_eq("sat_q_e4", {60'd0, qb}, 64'd0);
      check_eq("sat_ovf_e4", {63'd0, ovfb}, 64'd1);

      // Load clamp beats enable, then wraps up from the clamped maximum.
      set_in(1'b0, 1'b1, 1'b1, 1'b1, 16'd13);
      cycle();
      check_eq("clamp_q", {60'd0, qa}, 64'd9);
      check_eq("clamp_ovf", {63'd0, ovfa}, 64'd0);
      set_in(1'b0, 1'b0, 1'b1, 1'b1, 16'd0);
      cycle();
      check_eq("clamp_wrap_q", {60'd0, qa}, 64'd0);
      check_eq("clamp_wrap_ovf", {63'd0, ovfa}, 64'd1);

      // Two-digit decimal cascade 00..99 and back to 00.
      set_in(1'b1, 1'b0, 1'b0, 1'b1, 16'd0);
      cycle();
      set_in(1'b0, 1'b0, 1'b1, 1'b1, 16'd0);
      repeat (99) cycle();
      check_eq("cascade_99", 64'(q1) * 10 + 64'(q0), 64'd99);
      cycle();
      check_eq("cascade_00", 64'(q1) * 10 + 64'(q0), 64'd0);
      check_eq("cascade_ovf", {63'd0, ovf1}, 64'd1);

      // Full-range binary roll-over both ways.
      set_in(1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF);
      cycle();
      set_in(1'b0, 1'b0, 1'b1, 1'b1, 16'd0);
      cycle();
      check_eq("full_up_q", {48'd0, qc}, 64'd0);
      check_eq("full_up_ovf", {63'd0, ovfc}, 64'd1);
      set_in(1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
      cycle();
      check_eq("full_dn_q", {48'd0, qc}, 64'hFFFF);
      check_eq("full_dn_ovf", {63'd0, ovfc}, 64'd1);

      // Random traffic with biased control and boundary-heavy load values.
      for (int k = 0; k < 400; k++) begin
         set_in($urandom_range(0, 24) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'hFFFF - 16'($urandom_range(0, 2)));
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/counter_mod_updown.md
Name: counter_mod_updown

Overview:
- Parametrised synchronous up/down counter. It generalises the fixed 16-bit enable-chained T-flip-flop counter to any width and any modulus.
- Adds parallel load, count direction, a wrap or saturate mode, a cascade terminal-count output and a registered overflow pulse.
- Used as the general counting primitive in later labs: clock dividers, BCD digit chains and event counters driving the hex displays.

Parameters:
- WIDTH, 16, counter width in bits. Must be 1 to 32.
- MODULUS, 65536, count range. Q spans 0..MODULUS-1. Must satisfy 2 <= MODULUS <= 2**WIDTH.
- MODE, 0, boundary behaviour. 0 = wrap, 1 = saturate.

Ports:
- Clk  in  1  rising-edge clock
- Clr  in  1  synchronous active-high reset
- En  in  1  count enable
- Up  in  1  direction. 1 = increment, 0 = decrement.
- Ld  in  1  synchronous parallel load
- D  in  WIDTH  load value
- Q  out  WIDTH  registered count
- Tc  out  1  combinational terminal count, for cascading into the next stage's En
- Ovf  out  1  registered one-cycle boundary pulse

Behaviour:
- Interface: single clock Clk. Reset Clr is synchronous and active-high, sampled on the rising edge of Clk only; no asynchronous path.
- Reset values: Q = 0, Ovf = 0. Tc follows from Q and the inputs.
- Priority at each rising edge: Clr > Ld > En. Exactly one action per cycle.
- Clr = 1: Q <= 0, Ovf <= 0, regardless of Ld and En. Clr asserted mid-count aborts the count in that cycle.
- Ld = 1 (Clr = 0):
  - Q <= D if D <= MODULUS-1, else Q <= MODULUS-1 (clamped).
  - Ovf <= 0. En is ignored in that cycle.
- En = 1, Up = 1, Q < MODULUS-1: Q <= Q+1, Ovf <= 0.
- En = 1, Up = 1, Q = MODULUS-1:
  - Wrap mode: Q <= 0.
  - Saturate mode: Q holds.
  - Both modes: Ovf <= 1.
- En = 1, Up = 0, Q > 0: Q <= Q-1, Ovf <= 0.
- En = 1, Up = 0, Q = 0:
  - Wrap mode: Q <= MODULUS-1.
  - Saturate mode: Q holds.
  - Both modes: Ovf <= 1.
- En = 0 (no Clr, no Ld): Q holds, Ovf <= 0.
- Ovf is a single-cycle pulse. It is high for the cycle after the boundary edge, and again on every further boundary step in saturate mode.
- Tc = En & ~Ld & ~Clr & ((Up & Q == MODULUS-1) | (~Up & Q == 0)).
  - Zero-latency, same-cycle, so cascaded stages advance on the same edge, as in the T-chain scheme.
- Arithmetic: all compares and steps are done at WIDTH bits with no intermediate overflow. MODULUS-1 is computed at WIDTH+1 bits so that 2**WIDTH is legal.
- Full-range case MODULUS = 2**WIDTH: wrap behaves as natural binary roll-over.
- Direction change: Up may change on any cycle and takes effect on the next edge. There is no hysteresis or pipeline.
- Power-up: contents are undefined until the first Clr edge.

Decomposition:
- Shared header counter_defs.vh holds:
  - MODE_WRAP = 0, MODE_SAT = 1.
  - A localparam-computation macro for MAXVAL = MODULUS-1.
- One sub-module: counter_next. It is purely combinational:
  - Inputs: Q, Up, Ld, D, mode.
  - Outputs: the next value, the boundary flag and Tc.
- The top level holds only the Q/Ovf registers and Clr/En gating.

Test Plan:
- Reset and reset priority (WIDTH=4, MODULUS=10, wrap): Clr=1 with Ld=1, D=7, En=1 -> Q=0, Ovf=0. Count up 5 cycles, then Clr=1 -> Q=0 on that edge.
- Up-count wrap (WIDTH=4, MODULUS=10, wrap): En=1, Up=1 for 10 edges from 0 -> Q=1..9 then 0.
  - Tc=1 only while Q=9.
  - Ovf=1 only in the cycle Q=0 after the wrap.
- Down-count saturate (WIDTH=4, MODULUS=10, MODE=1): Ld D=2, then En=1, Up=0 for 4 edges -> Q=1, 0, 0, 0. Ovf=1 on the third and fourth edges.
- Load clamp and priority: D=13 with Ld=1, En=1 -> Q=9, Ovf=0. Next edge with Ld=0, Up=1 -> Q=0, Ovf=1.
- Cascade: two instances (MODULUS=10), stage0 Tc driving stage1 En, En=1 for 100 edges from 0 -> {Q1,Q0} runs 00..99 then 00. Stage1 advances on the same edge stage0 wraps.
- Full-range (WIDTH=16, default MODULUS): Ld D=16'hFFFF, Up=1 step -> Q=0, Ovf=1. Up=0 step -> Q=16'hFFFF, Ovf=1.
